// File: rtl/pipeline_hazard_ctl.sv
// Stall/flush sequencer for the 5-stage MIPS32 pipeline: drives the write enables and
// bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB for load-use, branch and memory hazards.
module pipeline_hazard_ctl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             ex_mem_flush,
    output logic             mem_wb_write,
    output logic             mem_wb_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [9:0] TIMEOUT_C = 10'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [9:0]       wcnt_q, wcnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign lu = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        mem_error_d  = mem_error_q;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_write = 1'b0;
        mem_wb_flush = 1'b0;
        // Every control stays deasserted while reset is held low.
        if (reset) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
            unique case (state_q)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        state_d      = MEM_WAIT;
                        wcnt_d       = 10'd1;
                    end else if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_flush  = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready && (wcnt_q < TIMEOUT_C)) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        wcnt_d       = wcnt_q + 10'd1;
                    end else begin
                        // Release cycle: normal or forced by timeout; a pending load-use still bubbles.
                        if (!dmem_ready) begin
                            mem_error_d = 1'b1;
                        end
                        if (lu) begin
                            pc_write    = 1'b0;
                            if_id_write = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                        state_d = RUN;
                        wcnt_d  = 10'd0;
                    end
                end
                default: begin
                    state_d = RUN;
                    wcnt_d  = 10'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_write) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            wcnt_q      <= 10'd0;
            mem_error_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_error_q <= mem_error_d;
            stall_q     <= stall_d;
        end
    end

    assign mem_error    = mem_error_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Directed bench for pipeline_hazard_ctl with a cycle-level behavioural model checked every cycle.
module tb_pipeline_hazard_ctl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    localparam logic [8:0] A_NORMAL = 9'b110101010;
    localparam logic [8:0] A_FLUSH  = 9'b111111110;
    localparam logic [8:0] A_BUBBLE = 9'b000111010;
    localparam logic [8:0] A_FREEZE = 9'b000000011;
    localparam logic [8:0] A_RESET  = 9'b000000000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          id_ex_mem_read = 1'b0;
    logic [4:0]    id_ex_rt = 5'd0;
    logic [4:0]    if_id_rs = 5'd0;
    logic [4:0]    if_id_rt = 5'd0;
    logic          branch_taken = 1'b0;
    logic          dmem_req = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic          ex_mem_write, ex_mem_flush, mem_wb_write, mem_wb_flush;
    logic          mem_error;
    logic [CW-1:0] stall_cycles;
    logic [8:0]    ctl;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: waiting on memory, cycles waited, sticky error, stall count.
    bit m_wait   = 1'b0;
    int m_wcnt   = 0;
    bit m_err    = 1'b0;
    int m_stalls = 0;

    pipeline_hazard_ctl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
        .mem_wb_write(mem_wb_write), .mem_wb_flush(mem_wb_flush),
        .mem_error(mem_error), .stall_cycles(stall_cycles)
    );

    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                  ex_mem_write, ex_mem_flush, mem_wb_write, mem_wb_flush};

    always #5 clk = ~clk;

    function automatic bit hazard();
        return id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
    endfunction

    // Which pipeline action the current cycle calls for.
    function automatic logic [8:0] action();
        if (!reset) return A_RESET;
        if (!m_wait) begin
            if (dmem_req && !dmem_ready) return A_FREEZE;
            if (branch_taken) return A_FLUSH;
            if (hazard()) return A_BUBBLE;
            return A_NORMAL;
        end
        if (!dmem_ready && m_wcnt < TO) return A_FREEZE;
        return hazard() ? A_BUBBLE : A_NORMAL;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_wait = 1'b0; m_wcnt = 0; m_err = 1'b0; m_stalls = 0;
        end else begin
            logic [8:0] a;
            a = action();
            if (!a[8] && m_stalls < MAXC) m_stalls++;
            if (!m_wait) begin
                if (a == A_FREEZE) begin m_wait = 1'b1; m_wcnt = 1; end
            end else if (a == A_FREEZE) begin
                m_wcnt++;
            end else begin
                if (!dmem_ready) m_err = 1'b1;
                m_wait = 1'b0; m_wcnt = 0;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, got, got, exp, exp);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        e = action();
        n_checks++;
        if (ctl === e && mem_error === m_err && int'(stall_cycles) == m_stalls) n_pass++;
        else $display("FAIL cycle_model at %0t: got ctl=%b err=%b stalls=%0d, expected ctl=%b err=%b stalls=%0d",
                      $time, ctl, mem_error, stall_cycles, e, m_err, m_stalls);
    end

    task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic req, input logic rdy);
        id_ex_mem_read = mr; id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt;
        branch_taken = br; dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        to_next();
        reset = 1'b1;
    endtask

    initial begin
        #2;
        check("reset_ctl", int'(ctl), 0);
        check("reset_stalls", int'(stall_cycles), 0);
        to_next();
        reset = 1'b1;

        // Load-use: one bubble then free flow; rt=0 never stalls.
        drive(1, 5'd8, 5'd8, 5'd3, 0, 0, 0);
        to_negedge(); check("lu_ctl", int'(ctl), int'(9'b000111010));
        to_next();
        drive(0, 5'd8, 5'd1, 5'd2, 0, 0, 0);
        to_negedge(); check("lu_after_ctl", int'(ctl), int'(9'b110101010));
        check("lu_stalls", int'(stall_cycles), 1);
        to_next();
        drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        to_negedge(); check("lu_r0_ctl", int'(ctl), int'(9'b110101010));
        to_next();

        // Taken branch overrides a concurrent load-use.
        drive(1, 5'd9, 5'd4, 5'd9, 1, 0, 0);
        to_negedge(); check("br_ctl", int'(ctl), int'(9'b111111110));
        to_next();
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        to_negedge(); check("br_stalls", int'(stall_cycles), 1);
        to_next();

        // Memory wait of three cycles, then release.
        reset_pulse();
        drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            to_negedge(); check("mw_freeze_ctl", int'(ctl), int'(9'b000000011));
            to_next();
        end
        dmem_ready = 1'b1;
        to_negedge(); check("mw_release_ctl", int'(ctl), int'(9'b110101010));
        to_next();
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        to_negedge(); check("mw_stalls", int'(stall_cycles), 3);
        check("mw_run_ctl", int'(ctl), int'(9'b110101010));
        to_next();

        // Timeout: four frozen cycles then forced release and sticky error.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        for (int i = 0; i < TO; i++) begin
            to_negedge(); check("to_freeze_ctl", int'(ctl), int'(9'b000000011));
            to_next();
        end
        to_negedge(); check("to_release_ctl", int'(ctl), int'(9'b110101010));
        check("to_err_before", int'(mem_error), 0);
        to_next();
        drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
        to_negedge(); check("to_err_set", int'(mem_error), 1);
        to_next();
        drive(0, 5'd0, 5'd0, 5'd0, 1, 1, 1);
        to_next();
        to_negedge(); check("to_err_sticky", int'(mem_error), 1);
        to_next();

        // Asynchronous reset while waiting on memory.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        to_next();
        #2 reset = 1'b0;
        #1 check("async_ctl", int'(ctl), 0);
        check("async_err", int'(mem_error), 0);
        to_next();
        reset = 1'b1;
        dmem_req = 1'b0;
        to_negedge(); check("post_reset_run", int'(ctl), int'(9'b110101010));
        check("post_reset_stalls", int'(stall_cycles), 0);
        to_next();

        // Saturation of the stall counter.
        drive(1, 5'd12, 5'd1, 5'd12, 0, 0, 0);
        for (int i = 0; i < 20; i++) to_next();
        to_negedge(); check("sat_stalls", int'(stall_cycles), 15);
        to_next();
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        to_negedge(); check("sat_hold", int'(stall_cycles), 15);
        to_next();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
